// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared flit types and NoC build constants.
//   flit_type_t   : flit type carried in the top two bits of fdata
//   s_flit_req_t  : flit payload with valid and vc_id
//   s_flit_resp_t : ready returned toward the flit source
package ravenoc_pkg;

   localparam int unsigned FLIT_WIDTH  = 34;
   localparam int unsigned FLIT_TP_MSB = FLIT_WIDTH - 1;
   localparam int unsigned N_VIRT_CHN  = 4;
   localparam bit          H_PRIORITY  = 1'b1;
   localparam int unsigned VC_ID_W     = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

   typedef enum logic [1:0] {
      HEAD      = 2'b00,
      BODY      = 2'b01,
      TAIL      = 2'b10,
      HEAD_TAIL = 2'b11
   } flit_type_t;

   typedef struct packed {
      logic [FLIT_WIDTH-1:0] fdata;
      logic                  valid;
      logic [VC_ID_W-1:0]    vc_id;
   } s_flit_req_t;

   typedef struct packed {
      logic ready;
   } s_flit_resp_t;

   // Extract the flit type field from a flit payload.
   function automatic flit_type_t flit_type(input logic [FLIT_WIDTH-1:0] fdata);
      return flit_type_t'(fdata[FLIT_TP_MSB -: 2]);
   endfunction

endpackage

// File: rtl/vc_wormhole_arbiter_if.sv
// vc_wormhole_arbiter_if: flit handshake bundle between the VC buffers,
// the wormhole arbiter and the output link.
//   vc_req_i / vc_resp_o    : per-VC flit requests and readies
//   fout_req_o / fout_resp_i: selected flit and downstream ready
//   credit_i                : per-VC one-cycle credit return pulses
// Modports: slave = arbiter side, master = buffers/link side.
interface vc_wormhole_arbiter_if #(
   parameter int unsigned N_VC = ravenoc_pkg::N_VIRT_CHN
) ();

   ravenoc_pkg::s_flit_req_t  [N_VC-1:0] vc_req_i;
   ravenoc_pkg::s_flit_resp_t [N_VC-1:0] vc_resp_o;
   ravenoc_pkg::s_flit_req_t             fout_req_o;
   ravenoc_pkg::s_flit_resp_t            fout_resp_i;
   logic                      [N_VC-1:0] credit_i;

   modport slave (
      input  vc_req_i,
      output vc_resp_o,
      output fout_req_o,
      input  fout_resp_i,
      input  credit_i
   );

   modport master (
      output vc_req_i,
      input  vc_resp_o,
      input  fout_req_o,
      output fout_resp_i,
      output credit_i
   );

endinterface

// File: rtl/vc_credit_counter.sv
// vc_credit_counter: saturating downstream credit counter for one VC.
//   clk, arst : clock, synchronous active-high reset
//   xfer      : a flit of this VC left on the output link this cycle
//   credit    : one credit returned for this VC this cycle
//   cred      : credits currently available
//   err       : sticky, a credit arrived while already at CREDITS
module vc_credit_counter #(
   parameter  int unsigned CREDITS = 4,
   localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
   input  logic          clk,
   input  logic          arst,
   input  logic          xfer,
   input  logic          credit,
   output logic [CW-1:0] cred,
   output logic          err
);

   // Transfer and return in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (arst) begin
         cred <= CW'(CREDITS);
         err  <= 1'b0;
      end else if (xfer && !credit) begin
         cred <= cred - CW'(1);
      end else if (credit && !xfer) begin
         if (cred == CW'(CREDITS)) begin
            err <= 1'b1;
         end else begin
            cred <= cred + CW'(1);
         end
      end
   end

endmodule

// File: rtl/vc_wormhole_arbiter.sv
// vc_wormhole_arbiter: packet-level arbiter sharing one output port among
// N_VC virtual channels, with per-VC downstream credit tracking.
//   clk, arst    : clock, synchronous active-high reset
//   bus          : vc_wormhole_arbiter_if.slave (VC flits in, flit out)
//   locked_o     : a packet currently owns the port
//   lock_vc_o    : owning VC, meaningful while locked_o is set
//   credit_err_o : sticky credit overflow flag
// Build option RAVENOC_RR_ARB_EN: round-robin head arbitration instead of
// fixed priority (direction set by H_PRIORITY).
module vc_wormhole_arbiter #(
   parameter  int unsigned N_VC       = ravenoc_pkg::N_VIRT_CHN,
   parameter  int unsigned CREDITS    = 4,
   parameter  bit          H_PRIORITY = ravenoc_pkg::H_PRIORITY,
   localparam int unsigned VC_W       = $clog2((N_VC > 1) ? N_VC : 2),
   localparam int unsigned CW         = $clog2(CREDITS + 1)
) (
   input  logic                  clk,
   input  logic                  arst,
   vc_wormhole_arbiter_if.slave  bus,
   output logic                  locked_o,
   output logic [VC_W-1:0]       lock_vc_o,
   output logic                  credit_err_o
);

   import ravenoc_pkg::*;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                   state;
   logic [N_VC-1:0][CW-1:0]  cred;
   logic [N_VC-1:0]          cred_ok;
   logic [N_VC-1:0]          eligible;
   logic [N_VC-1:0]          xfer_vec;
   logic [N_VC-1:0]          cerr;
   logic [VC_W-1:0]          sel;
   logic [VC_W-1:0]          idx;
   logic                     sel_ok;
   logic                     xfer;
   flit_type_t               sel_type;

   // Per-VC credit counters.
   for (genvar v = 0; v < N_VC; v++) begin : g_cred
      vc_credit_counter #(.CREDITS(CREDITS)) u_cred (
         .clk    (clk),
         .arst   (arst),
         .xfer   (xfer_vec[v]),
         .credit (bus.credit_i[v]),
         .cred   (cred[v]),
         .err    (cerr[v])
      );
   end

   assign credit_err_o = |cerr;

   // A VC may open a packet only with a head flit and a free credit.
   always_comb begin
      cred_ok  = '0;
      eligible = '0;
      for (int v = 0; v < N_VC; v++) begin
         cred_ok[v]  = (cred[v] != '0);
         eligible[v] = bus.vc_req_i[v].valid && cred_ok[v] &&
                       (flit_type(bus.vc_req_i[v].fdata) inside {HEAD, HEAD_TAIL});
      end
   end

`ifdef RAVENOC_RR_ARB_EN
   logic [VC_W-1:0] rr_ptr;

   // Pointer follows the last VC granted a head.
   always_ff @(posedge clk) begin
      if (arst) begin
         rr_ptr <= VC_W'(N_VC - 1);
      end else if (xfer && (state == IDLE)) begin
         rr_ptr <= sel;
      end
   end
`endif

   // Owner only while locked; otherwise first eligible VC in search order.
   always_comb begin
      sel    = '0;
      idx    = '0;
      sel_ok = 1'b0;
      if (state == LOCKED) begin
         sel    = lock_vc_o;
         sel_ok = bus.vc_req_i[lock_vc_o].valid && cred_ok[lock_vc_o];
      end else begin
         for (int i = 0; i < N_VC; i++) begin
`ifdef RAVENOC_RR_ARB_EN
            idx = VC_W'((int'(rr_ptr) + i + 1) % int'(N_VC));
`else
            idx = H_PRIORITY ? VC_W'(N_VC - 1 - i) : VC_W'(i);
`endif
            if (!sel_ok && eligible[idx]) begin
               sel    = idx;
               sel_ok = 1'b1;
            end
         end
      end
   end

   assign sel_type = flit_type(bus.vc_req_i[sel].fdata);
   assign xfer     = sel_ok && bus.fout_resp_i.ready;

   // Zero-cycle datapath from the selected VC to the output link.
   always_comb begin
      bus.fout_req_o = '0;
      bus.vc_resp_o  = '0;
      xfer_vec       = '0;
      if (sel_ok) begin
         bus.fout_req_o = bus.vc_req_i[sel];
      end
      if (xfer) begin
         bus.vc_resp_o[sel].ready = 1'b1;
         xfer_vec[sel]            = 1'b1;
      end
   end

   // Lock on a HEAD transfer, release on the owner's TAIL transfer.
   always_ff @(posedge clk) begin
      if (arst) begin
         state     <= IDLE;
         locked_o  <= 1'b0;
         lock_vc_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer && (sel_type == HEAD)) begin
                  state     <= LOCKED;
                  locked_o  <= 1'b1;
                  lock_vc_o <= sel;
               end
            end
            LOCKED: begin
               if (xfer && (sel_type == TAIL)) begin
                  state    <= IDLE;
                  locked_o <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vc_wormhole_arbiter.sv
// tb_vc_wormhole_arbiter: directed packet scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a packet-level reference model of the arbiter and credit rules.
module tb_vc_wormhole_arbiter;
   import ravenoc_pkg::*;

   localparam int NV = 4;
   localparam int CR = 4;
   localparam int FW = FLIT_WIDTH;

   logic           clk = 1'b0;
   logic           arst;
   logic           locked_o;
   logic [1:0]     lock_vc_o;
   logic           credit_err_o;

   int             n_cmp = 0;
   int             n_bad = 0;

   // Reference model state
   int             m_cred [NV];
   bit             m_locked;
   int             m_lv;
   int             m_ptr;
   bit             m_err;
   logic [NV-1:0]  last_xf;

   // Random traffic sources and downstream buffer occupancy
   logic [FW-1:0]  q [NV][$];
   int             ds [NV];

   vc_wormhole_arbiter_if #(.N_VC(NV)) bus ();

   vc_wormhole_arbiter #(
      .N_VC       (NV),
      .CREDITS    (CR),
      .H_PRIORITY (1'b1)
   ) dut (
      .clk          (clk),
      .arst         (arst),
      .bus          (bus),
      .locked_o     (locked_o),
      .lock_vc_o    (lock_vc_o),
      .credit_err_o (credit_err_o)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic flit_type_t ftype(logic [FW-1:0] d);
      return flit_type_t'(d[FW-1:FW-2]);
   endfunction

   function automatic s_flit_req_t mk(int v, flit_type_t t, logic [31:0] d);
      s_flit_req_t f;
      f.fdata = {t, d};
      f.valid = 1'b1;
      f.vc_id = 2'(v);
      return f;
   endfunction

   function automatic logic [NV-1:0] rdy();
      logic [NV-1:0] r;
      for (int v = 0; v < NV; v++) r[v] = bus.vc_resp_o[v].ready;
      return r;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < NV; v++) m_cred[v] = CR;
      m_locked = 1'b0;
      m_lv     = 0;
      m_ptr    = NV - 1;
      m_err    = 1'b0;
   endtask

   // Check outputs against the model for the current inputs, advance the
   // model to the next cycle, then move past the clock edge.
   task automatic step();
      int            sel;
      int            v;
      bit            ok;
      logic [63:0]   ef;
      logic [NV-1:0] er;
      flit_type_t    t;
      sel = 0;
      ok  = 1'b0;
      if (m_locked) begin
         sel = m_lv;
         ok  = bus.vc_req_i[m_lv].valid && (m_cred[m_lv] > 0);
      end else begin
         for (int k = 0; k < NV; k++) begin
`ifdef RAVENOC_RR_ARB_EN
            v = (m_ptr + 1 + k) % NV;
`else
            v = NV - 1 - k;
`endif
            t = ftype(bus.vc_req_i[v].fdata);
            if (!ok && bus.vc_req_i[v].valid && (m_cred[v] > 0) &&
                (t == HEAD || t == HEAD_TAIL)) begin
               sel = v;
               ok  = 1'b1;
            end
         end
      end
      ef = ok ? 64'(bus.vc_req_i[sel]) : 64'd0;
      er = '0;
      if (ok && bus.fout_resp_i.ready) er[sel] = 1'b1;
      chk("fout_req", 64'(bus.fout_req_o), ef);
      chk("vc_ready", 64'(rdy()), 64'(er));
      chk("locked", 64'(locked_o), 64'(m_locked));
      if (m_locked) chk("lock_vc", 64'(lock_vc_o), 64'(m_lv));
      chk("credit_err", 64'(credit_err_o), 64'(m_err));

      t = ftype(bus.vc_req_i[sel].fdata);
      for (int u = 0; u < NV; u++) begin
         if (er[u] && !bus.credit_i[u]) m_cred[u]--;
         else if (bus.credit_i[u] && !er[u]) begin
            if (m_cred[u] == CR) m_err = 1'b1;
            else m_cred[u]++;
         end
      end
      if (er != '0) begin
         if (!m_locked) begin
            m_ptr = sel;
            if (t == HEAD) begin
               m_locked = 1'b1;
               m_lv     = sel;
            end
         end else if (t == TAIL) begin
            m_locked = 1'b0;
         end
      end
      if (arst) model_reset();
      last_xf = er;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      #2;
      step();
   endtask

   task automatic push_pkt(int v);
      int len;
      len = $urandom_range(0, 3);
      if (len == 0) begin
         q[v].push_back({HEAD_TAIL, 32'($urandom)});
      end else begin
         q[v].push_back({HEAD, 32'($urandom)});
         for (int i = 1; i < len; i++) q[v].push_back({BODY, 32'($urandom)});
         q[v].push_back({TAIL, 32'($urandom)});
      end
   endtask

   initial begin
      logic [NV-1:0] exp_g;
      s_flit_req_t   f;
      logic [NV-1:0] cr;

      arst                  = 1'b1;
      bus.vc_req_i          = '0;
      bus.fout_resp_i.ready = 1'b0;
      bus.credit_i          = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      arst = 1'b0;

      // Reset values
      #2;
      chk("rst_locked", 64'(locked_o), 64'd0);
      chk("rst_err", 64'(credit_err_o), 64'd0);
      chk("rst_fout", 64'(bus.fout_req_o), 64'd0);
      chk("rst_rdy", 64'(rdy()), 64'd0);
      step();

      // VC0: HEAD, BODY, TAIL with downstream always ready
      bus.fout_resp_i.ready = 1'b1;
      bus.vc_req_i[0] = mk(0, HEAD, 32'h1111_0000);
      #2;
      chk("B_head_rdy", 64'(rdy()), 64'h1);
      chk("B_head_fout", 64'(bus.fout_req_o), 64'(mk(0, HEAD, 32'h1111_0000)));
      chk("B_head_unlocked", 64'(locked_o), 64'd0);
      step();
      bus.vc_req_i[0] = mk(0, BODY, 32'h1111_0001);
      #2;
      chk("B_body_rdy", 64'(rdy()), 64'h1);
      chk("B_body_locked", 64'(locked_o), 64'd1);
      step();
      bus.vc_req_i[0] = mk(0, TAIL, 32'h1111_0002);
      #2;
      chk("B_tail_rdy", 64'(rdy()), 64'h1);
      chk("B_tail_locked", 64'(locked_o), 64'd1);
      step();
      bus.vc_req_i = '0;
      #2;
      chk("B_released", 64'(locked_o), 64'd0);
      step();

      // VC0 has 1 credit left: HEAD uses it, BODY stalls until a credit returns
      bus.vc_req_i[0] = mk(0, HEAD, 32'h2222_0000);
      #2;
      chk("C_head_rdy", 64'(rdy()), 64'h1);
      step();
      bus.vc_req_i[0] = mk(0, BODY, 32'h2222_0001);
      #2;
      chk("C_nocred_valid", 64'(bus.fout_req_o.valid), 64'd0);
      chk("C_nocred_rdy", 64'(rdy()), 64'h0);
      step();
      bus.credit_i = 4'b0001;
      #2;
      chk("C_credit_cycle_rdy", 64'(rdy()), 64'h0);
      step();
      bus.credit_i = 4'b0000;
      #2;
      chk("C_body_after_credit", 64'(rdy()), 64'h1);
      step();
      bus.vc_req_i[0] = mk(0, TAIL, 32'h2222_0002);
      bus.credit_i    = 4'b0001;
      #2;
      chk("C_tail_stalled", 64'(rdy()), 64'h0);
      step();
      #2;
      chk("C_tail_with_credit", 64'(rdy()), 64'h1);
      step();
      // cred0 must still be 1: three returns reach CREDITS, the fourth overflows
      bus.vc_req_i = '0;
      repeat (3) cyc();
      #2;
      chk("C_err_before_overflow", 64'(credit_err_o), 64'd0);
      step();
      bus.credit_i = '0;
      #2;
      chk("C_err_set", 64'(credit_err_o), 64'd1);
      step();

      // VC1 owns the port; VC2 HEAD waits until after VC1's TAIL
      bus.vc_req_i[1] = mk(1, HEAD, 32'h3333_0000);
      #2;
      chk("D_vc1_head", 64'(rdy()), 64'h2);
      step();
      bus.vc_req_i[1] = mk(1, BODY, 32'h3333_0001);
      bus.vc_req_i[2] = mk(2, HEAD, 32'h4444_0000);
      #2;
      chk("D_vc2_blocked_body", 64'(rdy()), 64'h2);
      step();
      bus.vc_req_i[1] = mk(1, TAIL, 32'h3333_0002);
      #2;
      chk("D_vc2_blocked_tail", 64'(rdy()), 64'h2);
      step();
      bus.vc_req_i[1] = '0;
      #2;
      chk("D_vc2_head", 64'(rdy()), 64'h4);
      chk("D_unlocked", 64'(locked_o), 64'd0);
      step();
      bus.vc_req_i[2] = mk(2, TAIL, 32'h4444_0001);
      #2;
      chk("D_vc2_lock", 64'(lock_vc_o), 64'd2);
      step();
      bus.vc_req_i = '0;

      // Refill VC1/VC2, then VC0 and VC1 offer HEAD_TAIL continuously
      bus.credit_i = 4'b0110;
      repeat (2) cyc();
      bus.credit_i = 4'b0010;
      cyc();
      bus.credit_i    = 4'b0011;
      bus.vc_req_i[0] = mk(0, HEAD_TAIL, 32'h5555_0000);
      bus.vc_req_i[1] = mk(1, HEAD_TAIL, 32'h5555_0001);
      for (int i = 0; i < 4; i++) begin
`ifdef RAVENOC_RR_ARB_EN
         exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0010;
`else
         exp_g = 4'b0010;
`endif
         #2;
         chk("E_grant", 64'(rdy()), 64'(exp_g));
         step();
      end
      chk("E_err_sticky", 64'(credit_err_o), 64'd1);
      bus.vc_req_i = '0;
      bus.credit_i = '0;

      // Reset while VC3 owns the port
      bus.vc_req_i[3] = mk(3, HEAD, 32'h6666_0000);
      #2;
      chk("F_vc3_head", 64'(rdy()), 64'h8);
      step();
      bus.vc_req_i[3] = mk(3, BODY, 32'h6666_0001);
      #2;
      chk("F_locked_vc3", 64'(lock_vc_o), 64'd3);
      arst = 1'b1;
      step();
      arst = 1'b0;
      bus.vc_req_i = '0;
      #2;
      chk("F_lock_dropped", 64'(locked_o), 64'd0);
      chk("F_err_cleared", 64'(credit_err_o), 64'd0);
      step();
      bus.vc_req_i[3] = mk(3, HEAD_TAIL, 32'h7777_0000);
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("F_cred_restored", 64'(rdy()), (i < 4) ? 64'h8 : 64'h0);
         step();
      end

      // Randomized traffic with a downstream buffer returning credits
      bus.vc_req_i = '0;
      arst         = 1'b1;
      cyc();
      arst = 1'b0;
      for (int v = 0; v < NV; v++) ds[v] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int v = 0; v < NV; v++) begin
            if (q[v].size() == 0 && $urandom_range(0, 2) == 0) push_pkt(v);
            f.vc_id = 2'(v);
            if (q[v].size() != 0 && $urandom_range(0, 3) != 0) begin
               f.fdata = q[v][0];
               f.valid = 1'b1;
            end else begin
               f.fdata = FW'({$urandom, $urandom});
               f.valid = 1'b0;
            end
            bus.vc_req_i[v] = f;
            cr[v] = (ds[v] > 0) && ($urandom_range(0, 1) == 1);
            if (cr[v]) ds[v]--;
         end
         bus.credit_i          = cr;
         bus.fout_resp_i.ready = ($urandom_range(0, 3) != 0);
         cyc();
         for (int v = 0; v < NV; v++) begin
            if (last_xf[v]) begin
               void'(q[v].pop_front());
               ds[v]++;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
